// File: rtl/ldm_stm_seq.sv
// ldm_stm_seq: expands an LDM/STM into ascending single-word accesses with optional base writeback
module ldm_stm_seq (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_start,
  input  logic [15:0] i_reglist,
  input  logic [31:0] i_base,
  input  logic [3:0]  i_base_code,
  input  logic        i_load,
  input  logic        i_up,
  input  logic        i_pre,
  input  logic        i_wback,
  output logic        o_mem_req,
  output logic [31:0] o_mem_addr,
  output logic        o_mem_we,
  output logic [3:0]  o_mem_reg_code,
  input  logic        i_mem_ack,
  output logic        o_wb_vld,
  output logic        o_wb_src,
  output logic [3:0]  o_wb_code,
  output logic [31:0] o_wb_op,
  output logic        o_busy,
  output logic        o_stall,
  output logic        o_done
);
  typedef enum logic [1:0] {IDLE, XFER, WBACK, DONE} state_t;
  state_t state, nxt;
  logic [15:0] mask;
  logic [31:0] addr, wb_val, n4, start_addr;
  logic [3:0]  base_code, low;
  logic [4:0]  cnt;
  logic        load, do_wb, last, ack_x, xfer, wb_ld, wb_b, go;
  always_comb begin
    cnt = '0;
    for (int i = 0; i < 16; i++) cnt = cnt + 5'(i_reglist[i]);
  end
  always_comb begin
    low = '0;
    for (int i = 15; i >= 0; i--) if (mask[i]) low = 4'(i);
  end
  assign n4 = {25'd0, cnt, 2'b00};
  // Every mode walks upward from the lowest address, so decrement modes start below the base.
  assign start_addr = i_up ? (i_pre ? i_base + 32'd4 : i_base)
                           : (i_pre ? i_base - n4 : i_base - n4 + 32'd4);
  assign last  = (mask & (mask - 16'd1)) == 16'd0;
  assign xfer  = state == XFER;
  assign ack_x = xfer && i_mem_ack;
  assign go    = state == IDLE && i_start;
  always_ff @(posedge clk)
    if (rst) state <= IDLE;
    else state <= nxt;
  always_comb begin
    nxt = state == IDLE  ? (i_start ? (|i_reglist ? XFER : DONE) : IDLE) :
          state == XFER  ? (ack_x && last ? (do_wb ? WBACK : DONE) : XFER) :
          state == WBACK ? DONE : IDLE;
  end
  always_ff @(posedge clk)
    if (rst) begin
      mask      <= '0;
      addr      <= '0;
      wb_val    <= '0;
      base_code <= '0;
      load      <= 1'b0;
      do_wb     <= 1'b0;
    end else if (go) begin
      mask      <= i_reglist;
      addr      <= start_addr;
      wb_val    <= i_up ? i_base + n4 : i_base - n4;
      base_code <= i_base_code;
      load      <= i_load;
      // A loaded base overrides the writeback value.
      do_wb     <= i_wback && !(i_load && i_reglist[i_base_code]);
    end else if (ack_x) begin
      mask <= mask & (mask - 16'd1);
      addr <= addr + 32'd4;
    end
  assign wb_ld = ack_x && load;
  assign wb_b  = state == WBACK;
  always_comb begin
    o_mem_req      = xfer;
    o_mem_addr     = xfer ? addr : '0;
    o_mem_we       = xfer && !load;
    o_mem_reg_code = xfer ? low : '0;
    o_wb_vld       = wb_ld || wb_b;
    o_wb_src       = wb_b;
    o_wb_code      = wb_b ? base_code : (wb_ld ? low : '0);
    o_wb_op        = wb_b ? wb_val : '0;
    o_busy         = state != IDLE;
    o_stall        = xfer || wb_b;
    o_done         = state == DONE;
  end
endmodule

// File: doc/ldm_stm_seq.md
# ldm_stm_seq

Sequencer for ARMv4 block data transfers (LDM/STM). It expands one multi-register instruction into a series of single-word memory accesses, one per set bit of the register list, in ascending register order. It drives the register-file write port on the writeback side, and it holds the upstream pipeline stalled until the transfer and any base writeback are complete. It sits between the EX stage, the memory controller and the EX/WB writeback path.

## Interface
No parameters.

- clk  in  1  clock, all state updates on rising edge
- rst  in  1  synchronous reset, active-high
- i_start  in  1  start pulse; sampled only in IDLE
- i_reglist  in  16  register list; bit n = Rn
- i_base  in  32  base register value
- i_base_code  in  4  base register number
- i_load  in  1  1 = LDM, 0 = STM
- i_up  in  1  U bit; 1 = increment
- i_pre  in  1  P bit; 1 = before
- i_wback  in  1  W bit; base writeback requested
- o_mem_req  out  1  memory access request
- o_mem_addr  out  32  word address of current access
- o_mem_we  out  1  1 = store
- o_mem_reg_code  out  4  register transferred by current access
- i_mem_ack  in  1  memory accepted/completed current access; load data valid this cycle
- o_wb_vld  out  1  register-file write enable
- o_wb_src  out  1  0 = memory data, 1 = o_wb_op
- o_wb_code  out  4  destination register
- o_wb_op  out  32  computed writeback value (base update)
- o_busy  out  1  state != IDLE
- o_stall  out  1  upstream pipeline enable = !o_stall
- o_done  out  1  one-cycle completion pulse

## Operation
- **FSM states:** IDLE, XFER, WBACK, DONE.
- **IDLE, i_start=1:**
  - Latch the list into a remaining-mask, latch base_code, load, wback and N = popcount(reglist).
  - Start address:
    - IA (P=0, U=1) = base
    - IB (P=1, U=1) = base+4
    - DA (P=0, U=0) = base−4N+4
    - DB (P=1, U=0) = base−4N
  - Writeback value: U ? base+4N : base−4N, computed modulo 2^32.
  - Next state is XFER, or DONE if reglist == 0. An empty list produces no access and no writeback.
- **XFER:**
  - o_mem_req=1, o_mem_we=!load, o_mem_addr = current address.
  - o_mem_reg_code = lowest set bit of the remaining mask.
  - On i_mem_ack:
    - Clear that bit and advance the address by 4.
    - If load: o_wb_vld=1, o_wb_src=0, o_wb_code = same code, in the same cycle.
  - When the last bit is acked, go to WBACK if wback && !(load && reglist[base_code]); otherwise go to DONE. On a load with the base in the list, the loaded value wins.
- **WBACK:** one cycle; o_wb_vld=1, o_wb_src=1, o_wb_code=base_code, o_wb_op = writeback value; then DONE.
- **DONE:** o_done=1 for one cycle; then IDLE.
- **Ordering:** Addresses always ascend, and the lowest register always takes the lowest address, for every mode.
- **R15:** treated as an ordinary code 15. Branch effects are handled elsewhere.
- **i_start while busy:** ignored. Inputs are not re-sampled after IDLE.

## Timing
- **Reset values:** every output is 0 and the state is IDLE.
- **Reset mid-operation:** state is IDLE and all outputs are 0 on the next edge. An outstanding request is dropped without waiting for ack.
- **Request handshake:** once o_mem_req rises, o_mem_addr, o_mem_we and o_mem_reg_code hold stable until the cycle of i_mem_ack.
  - If the access is not the last, req stays high and the next address appears in the cycle after ack. Back-to-back acks give one transfer per cycle.
  - i_mem_ack outside XFER is ignored.
- **Latency, with i_start at cycle 0 and ack every cycle:**
  - XFER occupies cycles 1..N.
  - WBACK is at cycle N+1 when taken.
  - o_done is at cycle N+2 (with WBACK) or N+1 (without).
  - Empty list: o_done at cycle 1.
- **Stall:** o_stall=1 in XFER and WBACK, 0 in IDLE and DONE. o_busy=1 in XFER, WBACK and DONE.
- **Write port:** o_wb_vld is never asserted in IDLE or DONE, and never for stores during XFER.

## Test plan
1. **LDMIA with writeback.** LDMIA base=0x1000, list=0x000E, W=1, base_code=0, ack every cycle.
   - Accesses: 0x1000/r1, 0x1004/r2, 0x1008/r3, each with wb_vld, src=0.
   - Cycle 4: WB r0=0x100C, src=1.
   - Cycle 5: o_done.
2. **STMDB with writeback.** STMDB base=0x2000, list=0x4010, W=1, base_code=13.
   - Accesses: 0x1FF8/r4, then 0x1FFC/r14, we=1, with no wb_vld during XFER.
   - WBACK: r13=0x1FF8.
3. **Delayed ack.** LDMIB base=0x100, list=0x0003, ack delayed 3 cycles per access.
   - addr=0x104, code 0 held stable for 4 cycles, then 0x108/r1.
   - o_stall high throughout.
4. **Empty list.** list=0x0000, W=1.
   - No o_mem_req, no o_wb_vld.
   - o_done at cycle 1.
5. **Base in load list.** LDMDA base=0x40, list=0x0021, base_code=5, W=1.
   - Accesses: 0x3C/r0, then 0x40/r5.
   - No WBACK cycle; o_done directly after the last ack.
6. **Reset and restart.** Assert rst during the second XFER access.
   - All outputs 0 and IDLE next cycle.
   - An i_start pulsed during busy in a fresh run is ignored; the transfer completes unchanged.
